// File: rtl/enet_mii_tx.sv
// ============================================================================
// enet_mii_tx -- MII transmit MAC for 10/100 Mbps Ethernet.
//
// Takes a 32-bit little-endian word stream (byte strobes + last flag) in the
// MII TX clock domain. Each frame goes out on MII nibbles in this order:
// preamble/SFD, payload, optional zero pad, FCS, then an enforced
// inter-frame gap. There is no clock crossing in this block.
//
// Optional feature: define ENET_MII_TX_PAD_EN to pad short frames with zero
// bytes up to MIN_FRAME_BYTES before the FCS. The pad bytes are included in
// the FCS. When the macro is undefined, the FCS follows the last payload
// byte directly, whatever the frame length.
//
// Parameters
//   IFG_NIBBLES      number of tx_en-low cycles between frames (>= 2)
//   MIN_FRAME_BYTES  minimum payload+pad bytes (used only with padding)
//
// Ports
//   clk_i        MII TX clock; every flop updates on the rising edge
//   rst_i        asynchronous, active-high reset
//   valid_i      input word valid
//   data_i       payload bytes; byte0 = [7:0] is sent first
//   strb_i       byte enables, contiguous from bit0; all ones unless last_i
//   last_i       final word of the frame
//   accept_o     word consumed this cycle (combinational)
//   mii_txd_o    transmit nibble, low nibble of each byte first (registered)
//   mii_tx_en_o  transmit enable (registered)
//   mii_tx_er_o  transmit error, pulsed for one cycle on underrun (registered)
//   busy_o       high in any state other than IDLE
// ============================================================================
module enet_mii_tx #(
    parameter int IFG_NIBBLES     = 24,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  strb_i,
    input  logic        last_i,
    output logic        accept_o,
    output logic [3:0]  mii_txd_o,
    output logic        mii_tx_en_o,
    output logic        mii_tx_er_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_PAD,
        S_FCS,
        S_DROP,
        S_IFG
    } state_t;

    // ------------------------------------------------------------------------
    // The FSM works one nibble ahead: on each clock edge it decides the nibble
    // that will be on the wire for the following cycle and loads it into the
    // output registers. The state registers therefore describe what has
    // already been emitted, not what is currently on the wire.
    // ------------------------------------------------------------------------
    state_t      state_q;
    logic [31:0] hold_q;        // word currently being serialised
    logic [3:0]  strb_q;
    logic        last_q;
    logic [2:0]  byte_idx_q;    // 0..3 = byte in hold_q, 4 = word used up
    logic        nib_hi_q;      // low nibble of the current byte already emitted
    logic [7:0]  cnt_q;         // preamble / FCS / IFG nibble counter
    logic [10:0] byte_cnt_q;    // payload+pad bytes, saturating at 2047
    logic [31:0] crc_q;
    logic [3:0]  txd_q;
    logic        tx_en_q;
    logic        tx_er_q;

    logic [7:0]  cur_byte;
    logic [7:0]  crc_byte;
    logic [31:0] crc_d;
    logic [10:0] byte_cnt_d;
    logic [31:0] fcs;
    logic        word_done;
    logic        end_frame;
    logic        pad_needed;

    // Reflected CRC-32 (poly 0x04C11DB7, reversed form 0xEDB88320), one byte.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                               input logic [7:0]  b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign cur_byte   = hold_q[{byte_idx_q[1:0], 3'b000} +: 8];
    assign crc_byte   = (state_q == S_PAD) ? 8'h00 : cur_byte;
    assign crc_d      = crc32_byte(crc_q, crc_byte);
    assign byte_cnt_d = (byte_cnt_q == 11'd2047) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign fcs        = ~crc_q;

    // Strobes are contiguous, so the first clear strobe bit marks the end of
    // the word. Only meaningful between bytes (low nibble not yet emitted).
    assign word_done = !nib_hi_q && (byte_idx_q[2] || !strb_q[byte_idx_q[1:0]]);

    // Frame payload is over when the held word was the last one, or when the
    // refill word carries no bytes at all (empty last word).
    assign end_frame = word_done && (last_q || (valid_i && !strb_i[0]));

`ifdef ENET_MII_TX_PAD_EN
    assign pad_needed = (byte_cnt_q < 11'(MIN_FRAME_BYTES));
`else
    assign pad_needed = 1'b0;
`endif

    always_comb begin
        accept_o = 1'b0;
        case (state_q)
            S_IDLE:  accept_o = valid_i;
            S_DATA:  accept_o = word_done && !last_q && valid_i;
            S_DROP:  accept_o = valid_i;
            default: accept_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            strb_q     <= '0;
            last_q     <= 1'b0;
            byte_idx_q <= '0;
            nib_hi_q   <= 1'b0;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            crc_q      <= 32'hFFFF_FFFF;
            txd_q      <= 4'h0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q   <= 4'h0;
                    tx_en_q <= 1'b0;
                    tx_er_q <= 1'b0;
                    if (valid_i) begin
                        hold_q     <= data_i;
                        strb_q     <= strb_i;
                        last_q     <= last_i;
                        byte_idx_q <= '0;
                        nib_hi_q   <= 1'b0;
                        byte_cnt_q <= '0;
                        crc_q      <= 32'hFFFF_FFFF;
                        // First preamble nibble goes out right away.
                        cnt_q      <= 8'd1;
                        txd_q      <= 4'h5;
                        tx_en_q    <= 1'b1;
                        state_q    <= S_PREAMBLE;
                    end
                end

                S_PREAMBLE: begin
                    tx_en_q <= 1'b1;
                    if (cnt_q == 8'd15) begin
                        txd_q   <= 4'hD;
                        state_q <= S_DATA;
                    end else begin
                        txd_q <= 4'h5;
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                S_DATA: begin
                    if (nib_hi_q) begin
                        // High nibble completes the byte: fold it into the CRC.
                        txd_q      <= cur_byte[7:4];
                        crc_q      <= crc_d;
                        byte_cnt_q <= byte_cnt_d;
                        byte_idx_q <= byte_idx_q + 3'd1;
                        nib_hi_q   <= 1'b0;
                    end else if (!word_done) begin
                        txd_q    <= cur_byte[3:0];
                        nib_hi_q <= 1'b1;
                    end else if (end_frame) begin
                        if (pad_needed) begin
                            txd_q    <= 4'h0;
                            nib_hi_q <= 1'b1;
                            state_q  <= S_PAD;
                        end else begin
                            txd_q   <= fcs[3:0];
                            cnt_q   <= 8'd1;
                            state_q <= S_FCS;
                        end
                    end else if (valid_i) begin
                        // Refill: the new word's first nibble follows with no gap.
                        hold_q     <= data_i;
                        strb_q     <= strb_i;
                        last_q     <= last_i;
                        byte_idx_q <= '0;
                        txd_q      <= data_i[3:0];
                        nib_hi_q   <= 1'b1;
                    end else begin
                        // Underrun: one error nibble, then discard the rest.
                        txd_q   <= 4'h0;
                        tx_er_q <= 1'b1;
                        state_q <= S_DROP;
                    end
                end

`ifdef ENET_MII_TX_PAD_EN
                S_PAD: begin
                    if (nib_hi_q) begin
                        txd_q      <= 4'h0;
                        crc_q      <= crc_d;
                        byte_cnt_q <= byte_cnt_d;
                        nib_hi_q   <= 1'b0;
                    end else if (pad_needed) begin
                        txd_q    <= 4'h0;
                        nib_hi_q <= 1'b1;
                    end else begin
                        txd_q   <= fcs[3:0];
                        cnt_q   <= 8'd1;
                        state_q <= S_FCS;
                    end
                end
`endif

                S_FCS: begin
                    if (cnt_q == 8'd8) begin
                        txd_q   <= 4'h0;
                        tx_en_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IFG;
                    end else begin
                        txd_q <= fcs[{cnt_q[2:0], 2'b00} +: 4];
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                S_DROP: begin
                    txd_q   <= 4'h0;
                    tx_en_q <= 1'b0;
                    tx_er_q <= 1'b0;
                    if (valid_i && last_i) begin
                        cnt_q   <= '0;
                        state_q <= S_IFG;
                    end
                end

                S_IFG: begin
                    // The IDLE cycle that accepts the next word is itself a
                    // tx_en-low cycle, so IFG holds one cycle less than the gap.
                    txd_q   <= 4'h0;
                    tx_en_q <= 1'b0;
                    tx_er_q <= 1'b0;
                    if (cnt_q == 8'(IFG_NIBBLES - 2)) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                default: begin
                    txd_q   <= 4'h0;
                    tx_en_q <= 1'b0;
                    tx_er_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mii_txd_o   = txd_q;
    assign mii_tx_en_o = tx_en_q;
    assign mii_tx_er_o = tx_er_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
